// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: sequencer states and default operand width.
package alu_pkg;

    localparam int unsigned ALU_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub8_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
interface serial_sub8_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic [N-1:0] D;
    logic         Bout;
    logic         busy;
    logic         done;

    modport master (
        output start, A, B, Bin,
        input  D, Bout, busy, done
    );

    modport slave (
        input  start, A, B, Bin,
        output D, Bout, busy, done
    );
endinterface

// File: rtl/serial_sub8_fullsub.sv
// One-bit combinational full subtractor: diff = x - y - bin, bout = borrow out.
module fullsub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one full-subtractor cell
// and a registered borrow; N-cycle latency behind a start/busy/done handshake.
module serial_sub8
    import alu_pkg::*;
#(
    parameter int unsigned N = ALU_W
) (
    input logic          clk,
    input logic          rst_n,
    serial_sub8_if.slave bus
);
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state, state_nx;
    logic [N-1:0]  a_sh, b_sh, res_sh, d_q;
    logic [CW-1:0] cnt;
    logic          borrow, bout_q;
    logic          diff_c, bout_c;
    logic          busy_c, done_c;

    fullsub u_fullsub (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (borrow),
        .diff (diff_c),
        .bout (bout_c)
    );

    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nx = RUN;
            RUN: begin
                busy_c = 1'b1;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.A;
                        b_sh   <= bus.B;
                        borrow <= bus.Bin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {diff_c, res_sh[N-1:1]};
                    borrow <= bout_c;
                    cnt    <= cnt + CW'(1);
                    // Result registers move only on the completion edge so D/Bout stay stable between ops.
                    if (cnt == LAST) begin
                        d_q    <= {diff_c, res_sh[N-1:1]};
                        bout_q <= bout_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.busy = busy_c;
    assign bus.done = done_c;
endmodule

// File: tb/tb_serial_sub8.sv
// Directed and random checks of serial_sub8 against hand-computed differences.
module tb_serial_sub8;
    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [N-1:0] prev_d = '0;
    logic         prev_b = 1'b0;

    serial_sub8_if #(.N(N)) bus ();

    serial_sub8 #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE->IDLE.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                          input bit disturb, input bit full);
        logic [N:0] ext;
        int         lat;
        int         busy_cnt;
        bit         seen;
        ext = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
        bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (disturb) begin
            bus.A = ~a; bus.B = a ^ 8'h5A; bus.Bin = ~bin;
        end
        lat = 0; busy_cnt = 0; seen = 0;
        while (!seen && lat < 20) begin
            if (bus.busy) busy_cnt++;
            if (bus.busy && bus.done) check_eq("busy_and_done", 1, 0);
            if (bus.done) seen = 1;
            else begin
                if (full) begin
                    check_eq("d_hold", bus.D, prev_d);
                    check_eq("bout_hold", bus.Bout, prev_b);
                end
                if (disturb && lat == 3) bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                lat++;
            end
        end
        if (!seen) check_eq("done_timeout", 0, 1);
        check_eq("latency", lat, N);
        if (full) check_eq("busy_cycles", busy_cnt, N);
        check_eq("d", bus.D, ext[N-1:0]);
        check_eq("bout", bus.Bout, ext[N]);
        prev_d = ext[N-1:0];
        prev_b = ext[N];
        if (disturb) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (full) begin
            check_eq("done_one_cycle", bus.done, 0);
            check_eq("idle_after_done", bus.busy, 0);
        end
    endtask

    initial begin
        bit saw_done;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_d", bus.D, 0);
        check_eq("rst_bout", bus.Bout, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'hB5, 8'hA7, 1'b0, 0, 1);
        run_op(8'hA7, 8'hB5, 1'b0, 0, 1);
        run_op(8'h00, 8'h00, 1'b1, 0, 1);
        run_op(8'h80, 8'h01, 1'b0, 0, 1);
        run_op(8'h3C, 8'h51, 1'b1, 1, 1);
        // The disturbing start on the DONE cycle must not have launched a new op.
        repeat (3) @(negedge clk);
        check_eq("no_queued_start", bus.busy, 0);

        // Abort mid-RUN with reset.
        bus.A = 8'hF0; bus.B = 8'h0F; bus.Bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_d", bus.D, 0);
        check_eq("abort_bout", bus.Bout, 0);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1;
        end
        check_eq("no_done_after_abort", saw_done, 0);
        prev_d = '0; prev_b = 1'b0;
        run_op(8'h12, 8'h34, 1'b1, 0, 1);

        for (int i = 0; i < 1000; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
